// File: rtl/multi_timer_starter.sv
// multi_timer_starter: NUM_CH independent interval timers that raise a
// held request on expiry. Each channel has a double-buffered configuration
// (pending buffer + active register), one-shot or periodic operation, and
// a sticky overrun flag for expiries that land on an unacknowledged request.
// Nothing starts until the shared DRAM-init flag has been captured.
module multi_timer_starter #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned CNT_WIDTH        = 32,
  parameter int unsigned INTERVAL_WIDTH   = 16,
  parameter int unsigned SHIFT            = 7,
  parameter int unsigned DEFAULT_INTERVAL = 16'h0100
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               rpc_init_completed_i,
  input  logic [NUM_CH-1:0]                  load_config_i,
  input  logic [NUM_CH*INTERVAL_WIDTH-1:0]   cfg_interval_i,
  input  logic [NUM_CH-1:0]                  cfg_mode_i,
  input  logic [NUM_CH-1:0]                  cfg_periodic_i,
  input  logic [NUM_CH-1:0]                  stop_i,
  output logic [NUM_CH-1:0]                  timer_req_o,
  input  logic [NUM_CH-1:0]                  timer_ack_i,
  output logic [NUM_CH-1:0]                  overrun_o,
  input  logic [NUM_CH-1:0]                  clear_overrun_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    REQ      = 2'd2
  } state_e;

  localparam logic [INTERVAL_WIDTH-1:0] DEF_IV = INTERVAL_WIDTH'(DEFAULT_INTERVAL);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE = CNT_WIDTH'(1);

  // Period in cycles for a given active configuration. A zero interval
  // would never expire, so it falls back to the default just like mode 0.
  function automatic logic [CNT_WIDTH-1:0] ceiling_f(
    input logic [INTERVAL_WIDTH-1:0] iv,
    input logic                      mode
  );
    logic [INTERVAL_WIDTH-1:0] eff;
    eff = mode ? iv : DEF_IV;
    if (eff == '0) eff = DEF_IV;
    return CNT_WIDTH'(eff) << SHIFT;
  endfunction

  logic init_q;

  // Sticky init flag, shared by all channels; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) init_q <= 1'b0;
    else if (rpc_init_completed_i) init_q <= 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]      ceil;
    logic                      at_ceil;

    logic [INTERVAL_WIDTH-1:0] act_iv_q, act_iv_d;
    logic                      act_mode_q, act_mode_d;
    logic                      act_per_q, act_per_d;

    logic [INTERVAL_WIDTH-1:0] buf_iv_q, buf_iv_d;
    logic                      buf_mode_q, buf_mode_d;
    logic                      buf_per_q, buf_per_d;
    logic                      buf_vld_q, buf_vld_d;

    logic                      ovr_q, ovr_d;
    logic                      take;
    logic                      ovr_set;
    logic [INTERVAL_WIDTH-1:0] cfg_iv;

    assign cfg_iv  = cfg_interval_i[k*INTERVAL_WIDTH +: INTERVAL_WIDTH];
    assign ceil    = ceiling_f(act_iv_q, act_mode_q);
    assign at_ceil = (cnt_q == (ceil - CNT_ONE));

    // Channel FSM and counter next state; also decides when the buffered
    // config is consumed (start from IDLE, or at an expiry boundary).
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      take       = 1'b0;
      ovr_set    = 1'b0;
      act_iv_d   = act_iv_q;
      act_mode_d = act_mode_q;
      act_per_d  = act_per_q;

      if (stop_i[k]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (init_q && buf_vld_q) begin
              state_d = COUNTING;
              cnt_d   = '0;
              take    = 1'b1;
            end
          end
          COUNTING: begin
            if (at_ceil) begin
              state_d = REQ;
              cnt_d   = '0;
              take    = buf_vld_q;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          REQ: begin
            if (act_per_q) begin
              // Periodic: keep time running so the period is preserved.
              // An expiry while still requesting is flagged as overrun
              // unless the ack arrives in that same cycle, in which case
              // the new expiry simply becomes the next request.
              if (at_ceil) begin
                cnt_d   = '0;
                ovr_set = ~timer_ack_i[k];
                take    = buf_vld_q;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
                if (timer_ack_i[k]) state_d = COUNTING;
              end
            end else begin
              cnt_d = '0;
              if (timer_ack_i[k]) state_d = IDLE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      if (take) begin
        act_iv_d   = buf_iv_q;
        act_mode_d = buf_mode_q;
        act_per_d  = buf_per_q;
      end
    end

    // Config buffer: a consume and a new load in the same cycle leaves the
    // new data valid.
    always_comb begin
      buf_iv_d   = buf_iv_q;
      buf_mode_d = buf_mode_q;
      buf_per_d  = buf_per_q;
      buf_vld_d  = buf_vld_q & ~take;
      if (load_config_i[k]) begin
        buf_iv_d   = cfg_iv;
        buf_mode_d = cfg_mode_i[k];
        buf_per_d  = cfg_periodic_i[k];
        buf_vld_d  = 1'b1;
      end
    end

    // Sticky overrun flag; a set in the same cycle as a clear wins.
    always_comb begin
      ovr_d = ovr_q;
      if (clear_overrun_i[k]) ovr_d = 1'b0;
      if (ovr_set)            ovr_d = 1'b1;
    end

    // Per-channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        act_iv_q   <= '0;
        act_mode_q <= 1'b0;
        act_per_q  <= 1'b0;
        buf_iv_q   <= '0;
        buf_mode_q <= 1'b0;
        buf_per_q  <= 1'b0;
        buf_vld_q  <= 1'b0;
        ovr_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        act_iv_q   <= act_iv_d;
        act_mode_q <= act_mode_d;
        act_per_q  <= act_per_d;
        buf_iv_q   <= buf_iv_d;
        buf_mode_q <= buf_mode_d;
        buf_per_q  <= buf_per_d;
        buf_vld_q  <= buf_vld_d;
        ovr_q      <= ovr_d;
      end
    end

    // Request comes straight from the state register, so an asynchronous
    // reset removes it without waiting for a clock edge.
    assign timer_req_o[k] = (state_q == REQ);
    assign overrun_o[k]   = ovr_q;
  end

endmodule

// File: tb/tb_multi_timer_starter.sv
// Testbench for multi_timer_starter: directed scenarios followed by random
// traffic, all checked every cycle against a deadline-based reference model.
module tb_multi_timer_starter;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int IW  = 8;
  localparam int SH  = 0;
  localparam int DEF = 6;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              rpc = 1'b0;
  logic [NCH-1:0]    load_config_i, cfg_mode_i, cfg_periodic_i, stop_i;
  logic [NCH-1:0]    timer_ack_i, clear_overrun_i, timer_req_o, overrun_o;
  logic [NCH*IW-1:0] cfg_interval_i;

  int    checks = 0;
  int    errors = 0;
  int    t = 0;
  int    n;
  string phase = "reset";

  // Reference model: each running channel has an absolute expiry deadline.
  bit m_init;
  bit m_run [NCH];
  bit m_pend[NCH];
  bit m_perd[NCH];
  bit m_ovr [NCH];
  bit m_bv  [NCH];
  bit b_per [NCH];
  int m_ceil[NCH];
  int m_dl  [NCH];
  int b_ceil[NCH];

  multi_timer_starter #(
    .NUM_CH(NCH), .CNT_WIDTH(CW), .INTERVAL_WIDTH(IW),
    .SHIFT(SH), .DEFAULT_INTERVAL(DEF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rpc_init_completed_i(rpc),
    .load_config_i(load_config_i), .cfg_interval_i(cfg_interval_i),
    .cfg_mode_i(cfg_mode_i), .cfg_periodic_i(cfg_periodic_i),
    .stop_i(stop_i), .timer_req_o(timer_req_o), .timer_ack_i(timer_ack_i),
    .overrun_o(overrun_o), .clear_overrun_i(clear_overrun_i)
  );

  always #5 clk = ~clk;

  function automatic int eff_ceil(int iv, bit mode);
    int base;
    base = (mode && iv != 0) ? iv : DEF;
    return base << SH;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %0d expected %0d", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 0;
    for (int k = 0; k < NCH; k++) begin
      m_run[k] = 0; m_pend[k] = 0; m_perd[k] = 0; m_ovr[k] = 0;
      m_bv[k] = 0; b_per[k] = 0; m_ceil[k] = DEF; m_dl[k] = 0; b_ceil[k] = DEF;
    end
  endtask

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_edge();
    bit init_old;
    init_old = m_init;
    for (int k = 0; k < NCH; k++) begin
      bit take, rearm, set_o, ack;
      take = 0; rearm = 0; set_o = 0; ack = timer_ack_i[k];
      if (stop_i[k]) begin
        m_run[k] = 0; m_pend[k] = 0;
      end else if (!m_run[k]) begin
        if (init_old && m_bv[k]) begin
          m_run[k] = 1; m_pend[k] = 0; take = 1; rearm = 1;
        end
      end else if (!m_pend[k]) begin
        if (t == m_dl[k]) begin
          m_pend[k] = 1; take = m_bv[k]; rearm = 1;
        end
      end else if (m_perd[k]) begin
        if (t == m_dl[k]) begin
          set_o = !ack; take = m_bv[k]; rearm = 1;
        end else if (ack) begin
          m_pend[k] = 0;
        end
      end else if (ack) begin
        m_run[k] = 0; m_pend[k] = 0;
      end
      if (take) begin
        m_ceil[k] = b_ceil[k]; m_perd[k] = b_per[k]; m_bv[k] = 0;
      end
      if (rearm) m_dl[k] = t + m_ceil[k];
      if (load_config_i[k]) begin
        b_ceil[k] = eff_ceil(int'(cfg_interval_i[k*IW +: IW]), cfg_mode_i[k]);
        b_per[k]  = cfg_periodic_i[k];
        m_bv[k]   = 1;
      end
      if (clear_overrun_i[k]) m_ovr[k] = 0;
      if (set_o) m_ovr[k] = 1;
    end
    if (rpc) m_init = 1;
  endtask

  task automatic clear_strobes();
    load_config_i = '0; stop_i = '0; timer_ack_i = '0; clear_overrun_i = '0; rpc = 1'b0;
  endtask

  // One clock: model update at the edge, compare outputs 1 time unit later,
  // then drop all one-cycle strobes.
  task automatic tick();
    @(posedge clk);
    t++;
    model_edge();
    #1;
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("%s_req%0d", phase, k), 32'(timer_req_o[k]), 32'(m_pend[k]));
      chk($sformatf("%s_ovr%0d", phase, k), 32'(overrun_o[k]), 32'(m_ovr[k]));
    end
    clear_strobes();
  endtask

  task automatic load(int k, int iv, bit mode, bit per);
    load_config_i[k] = 1'b1;
    cfg_interval_i[k*IW +: IW] = iv[IW-1:0];
    cfg_mode_i[k] = mode;
    cfg_periodic_i[k] = per;
  endtask

  task automatic wait_rise(int k, int maxc, output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (timer_req_o[k] !== 1'b1 && cnt < maxc);
  endtask

  task automatic wait_ovr(int k, int maxc, output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (overrun_o[k] !== 1'b1 && cnt < maxc);
  endtask

  initial begin
    clear_strobes();
    cfg_interval_i = '0; cfg_mode_i = '0; cfg_periodic_i = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", 32'(timer_req_o), 32'd0);
    chk("reset_ovr", 32'(overrun_o), 32'd0);
    rst_ni = 1'b1;
    t = 0;

    // One-shot ch0 interval 5, loaded before init
    phase = "oneshot";
    load(0, 5, 1, 0);
    repeat (3) tick();
    chk("no_start_before_init", 32'(timer_req_o[0]), 32'd0);
    rpc = 1'b1;
    wait_rise(0, 20, n);
    chk("oneshot_latency", n, 7);
    timer_ack_i[0] = 1'b1;
    tick();
    chk("oneshot_ack_drop", 32'(timer_req_o[0]), 32'd0);
    repeat (10) tick();
    chk("oneshot_no_repeat", 32'(timer_req_o[0]), 32'd0);

    // Periodic ch1 interval 4, acked each time
    phase = "periodic";
    load(1, 4, 1, 1);
    wait_rise(1, 20, n);
    chk("periodic_first", n, 6);
    for (int i = 0; i < 3; i++) begin
      timer_ack_i[1] = 1'b1;
      wait_rise(1, 20, n);
      chk("periodic_period", n, 4);
    end
    chk("periodic_no_ovr", 32'(overrun_o[1]), 32'd0);

    // Never acked: overrun sets, clears, and re-sets one period later
    phase = "overrun";
    wait_ovr(1, 20, n);
    chk("ovr_delay", n, 4);
    chk("ovr_req_held", 32'(timer_req_o[1]), 32'd1);
    clear_overrun_i[1] = 1'b1;
    wait_ovr(1, 20, n);
    chk("ovr_reset_delay", n, 4);
    stop_i[1] = 1'b1;
    tick();
    chk("stop_drops_req", 32'(timer_req_o[1]), 32'd0);
    clear_overrun_i[1] = 1'b1;
    tick();

    // Default interval for mode 0 and for a zero interval
    phase = "default";
    load(2, 3, 0, 0);
    wait_rise(2, 30, n);
    chk("mode0_default", n, 2 + DEF);
    timer_ack_i[2] = 1'b1;
    tick();
    load(2, 0, 1, 0);
    wait_rise(2, 30, n);
    chk("zero_iv_default", n, 2 + DEF);
    timer_ack_i[2] = 1'b1;
    tick();

    // Reload mid-count takes effect at the next expiry
    phase = "reload";
    load(3, 8, 1, 1);
    wait_rise(3, 30, n);
    chk("reload_first", n, 10);
    timer_ack_i[3] = 1'b1;
    tick();
    tick();
    load(3, 3, 1, 1);
    tick();
    wait_rise(3, 30, n);
    chk("reload_old_period", n, 5);
    for (int i = 0; i < 2; i++) begin
      timer_ack_i[3] = 1'b1;
      wait_rise(3, 30, n);
      chk("reload_new_period", n, 3);
    end

    // Stop ch2 while ch3 sits in REQ; ch2 restarts from a zero count
    phase = "stop";
    load(2, 5, 1, 1);
    repeat (4) tick();
    stop_i[2] = 1'b1;
    tick();
    chk("stop_ch2_idle", 32'(timer_req_o[2]), 32'd0);
    chk("stop_ch3_req", 32'(timer_req_o[3]), 32'd1);
    load(2, 5, 1, 1);
    wait_rise(2, 30, n);
    chk("restart_after_stop", n, 7);

    // Asynchronous reset in the middle of a cycle
    chk("pre_reset_req3", 32'(timer_req_o[3]), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_req", 32'(timer_req_o), 32'd0);
    chk("async_reset_ovr", 32'(overrun_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_ni = 1'b1;
    t = 0;

    // Init flag is cleared by reset
    phase = "post_reset";
    load(0, 2, 1, 1);
    repeat (5) tick();
    chk("post_reset_wait_init", 32'(timer_req_o[0]), 32'd0);

    // Random traffic
    phase = "random";
    for (int c = 0; c < 800; c++) begin
      if (c == 10) rpc = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 19) == 0)
          load(k, int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        timer_ack_i[k]     = ($urandom_range(0, 2) == 0);
        stop_i[k]          = ($urandom_range(0, 79) == 0);
        clear_overrun_i[k] = ($urandom_range(0, 14) == 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_timer_starter.md
MULTI_TIMER_STARTER -- requirements
Module: multi_timer_starter

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels, range 1..16.
REQ-002 Parameter CNT_WIDTH, default 32: per-channel counter width.
REQ-003 Parameter INTERVAL_WIDTH, default 16: per-channel interval field width; INTERVAL_WIDTH+SHIFT SHALL be at most CNT_WIDTH.
REQ-004 Parameter SHIFT, default 7: interval scaling; ceiling = interval << SHIFT.
REQ-005 Parameter DEFAULT_INTERVAL, default 16'h0100: interval used when cfg mode is 0 or the configured interval is 0.
REQ-006 Port clk_i, input, 1: clock, rising edge.
REQ-007 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 Port rpc_init_completed_i, input, 1: DRAM init done pulse; captured into a sticky status flag.
REQ-009 Port load_config_i, input, NUM_CH: per-channel config load strobe.
REQ-010 Port cfg_interval_i, input, NUM_CH x INTERVAL_WIDTH: per-channel interval.
REQ-011 Port cfg_mode_i, input, NUM_CH: 1 = use cfg_interval_i, 0 = use DEFAULT_INTERVAL.
REQ-012 Port cfg_periodic_i, input, NUM_CH: 1 = auto re-arm after ack, 0 = one-shot.
REQ-013 Port stop_i, input, NUM_CH: per-channel abort.
REQ-014 Port timer_req_o, input-side handshake, output, NUM_CH: expiry request, held until acked.
REQ-015 Port timer_ack_i, input, NUM_CH: expiry acknowledge.
REQ-016 Port overrun_o, output, NUM_CH: sticky flag, expiry occurred while request still pending.
REQ-017 Port clear_overrun_i, input, NUM_CH: clears the matching overrun_o bit.

Function
REQ-018 Each channel SHALL hold a config buffer (interval, mode, periodic, valid) and an active config register; load_config_i[k] writes the buffer and sets valid, overwriting any unconsumed entry.
REQ-019 Each channel SHALL run an FSM with states IDLE, COUNTING, REQ.
REQ-020 IDLE -> COUNTING when init flag = 1 and buffer valid = 1; the buffer is copied to the active register, valid is cleared, and the counter is set to 0 in the same cycle.
REQ-021 Effective ceiling = (mode ? interval : DEFAULT_INTERVAL) << SHIFT, zero-extended to CNT_WIDTH; an interval of 0 SHALL be replaced by DEFAULT_INTERVAL.
REQ-022 COUNTING: the counter increments by 1 each cycle; at cnt == ceiling-1, the FSM enters REQ and the counter returns to 0, so timer_req_o rises exactly ceiling cycles after COUNTING entry.
REQ-023 REQ: timer_req_o[k] = 1. Periodic channels keep counting; one-shot channels hold the counter at 0.
REQ-024 REQ with timer_ack_i[k] = 1: timer_req_o falls the next cycle. Periodic -> COUNTING with the counter continuing, preserving period. One-shot -> IDLE.
REQ-025 Periodic channel in REQ reaching ceiling-1 without ack: overrun_o[k] SHALL be set, the counter SHALL wrap to 0, and the FSM SHALL stay in REQ; the request is not duplicated.
REQ-026 Buffered config while in COUNTING or REQ SHALL be applied at the next expiry, at the cnt == ceiling-1 cycle: it is copied to active, valid is cleared, and counting restarts from 0 against the new ceiling.
REQ-027 stop_i[k] has highest priority: the FSM goes to IDLE, timer_req_o drops the next cycle, and the counter is cleared; buffer and overrun are untouched.
REQ-028 load_config_i coincident with buffer consumption: the new data SHALL be stored and valid SHALL remain 1.
REQ-029 Simultaneous overrun set and clear_overrun_i: set wins.
REQ-030 timer_ack_i outside REQ SHALL be ignored.
REQ-031 Channels SHALL be fully independent; the init flag is shared and is never cleared except by reset.

Reset
REQ-032 On rst_ni = 0, asynchronously: all FSMs to IDLE, counters = 0, buffers and active regs = 0, valid = 0, init flag = 0, timer_req_o = 0, overrun_o = 0.
REQ-033 Reset mid-count or mid-REQ SHALL drop timer_req_o immediately, without waiting for a clock edge.

Verification
REQ-034 SHIFT=0, ch0 load interval 5, mode 1, periodic 0, before the init pulse -> no activity until init; req rises 5 cycles after the COUNTING entry cycle; ack -> IDLE, no further req.
REQ-035 ch1 periodic interval 4, ack held 1 cycle after each req -> req rises every 4 cycles; overrun_o stays 0.
REQ-036 ch1 periodic interval 4, never acked -> req stays 1; overrun_o[1] = 1 4 cycles after req rise; clear_overrun_i clears it, and it re-sets 4 cycles later.
REQ-037 mode 0 and mode 1 with interval 0 -> ceiling = DEFAULT_INTERVAL<<SHIFT in both cases.
REQ-038 Periodic interval 8, load interval 3 mid-count -> current period completes at 8; subsequent periods are 3.
REQ-039 stop_i on ch2 while ch3 is in REQ -> ch2 goes to IDLE with its counter at 0; ch3 timing is unaffected; async reset during REQ -> req drops without a clock edge.
